wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//  Parametrised bridge from the core's valid/ack memory port to a Wishbone B4 classic master.
//  Successor to the combinational ibus/dbus pass-through.
//  - Registers all bus outputs.
//  - Handles wb_err_i.
//  - Aborts hung cycles with a timeout watchdog.
//  One instance per core port: ibus (WR_EN=0) or dbus.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data width; multiple of 8; SEL_W = DATA_W/8
//  WR_EN           1    0: writes unsupported; core_we_i ignored; wb_we_o tied 0
//  TIMEOUT_CYCLES  256  bus cycles waited for ack/err before abort; 0 disables watchdog
// PORTS
//  wb_clk_i      in   1        clock; all logic on rising edge
//  wb_rst_i      in   1        synchronous reset, active-high
//  core_valid_i  in   1        request valid; core holds it and its fields until core_ack_o
//  core_addr_i   in   ADDR_W   request address
//  core_data_i   in   DATA_W   write data
//  core_sel_i    in   SEL_W    byte enables
//  core_we_i     in   1        1 = write
//  core_data_o   out  DATA_W   read data; valid while core_ack_o=1
//  core_ack_o    out  1        one-cycle completion pulse
//  core_err_o    out  1        one-cycle error pulse; only together with core_ack_o
//  wb_adr_o      out  ADDR_W   Wishbone address
//  wb_dat_o      out  DATA_W   Wishbone write data
//  wb_dat_i      in   DATA_W   Wishbone read data
//  wb_we_o       out  1        Wishbone write enable
//  wb_sel_o      out  SEL_W    Wishbone byte selects
//  wb_stb_o      out  1        Wishbone strobe
//  wb_cyc_o      out  1        Wishbone cycle
//  wb_ack_i      in   1        Wishbone acknowledge
//  wb_err_i      in   1        Wishbone error
//  busy_o        out  1        1 while state = BUS
// BEHAVIOUR
//  Reset (wb_rst_i=1 at an edge): state=IDLE, timer=0, all outputs 0.
//  - Reset mid-cycle drops cyc/stb at that edge.
//  - No core_ack_o is produced for the aborted request.
//  FSM (2 states):
//  - IDLE: if core_valid_i=1 and core_ack_o=0:
//      latch addr/data/sel/we into wb_*_o; wb_cyc_o=wb_stb_o=1; timer=0; -> BUS.
//    A valid seen in the same cycle as a core_ack_o pulse is ignored. Min spacing is 1 idle cycle.
//  - BUS: wb_* outputs held stable; timer increments by 1 each cycle (saturating).
//      wb_err_i=1  -> core_ack_o=1, core_err_o=1; -> IDLE. Err wins over a simultaneous ack.
//      wb_ack_i=1  -> core_data_o<=wb_dat_i, core_ack_o=1; -> IDLE.
//      Timeout (TIMEOUT_CYCLES!=0, timer==TIMEOUT_CYCLES-1, no ack/err) -> core_ack_o=1, core_err_o=1; -> IDLE.
//    Every exit clears wb_cyc_o/wb_stb_o at the same edge.
//  Latency:
//  - core_valid_i sampled at edge N -> stb high from edge N.
//  - Ack sampled at edge M -> core_ack_o high for cycle M..M+1 (one cycle).
//  Output rules:
//  - core_data_o holds its last value otherwise; 0 after reset and on err/timeout.
//  - wb_we_o=0 for reads; wb_dat_o is don't-care on reads but still registered.
//  - Ack/err arriving in IDLE (late, after timeout) is ignored; no pulse generated.
//  - Timer width is clog2(TIMEOUT_CYCLES+1). Timer is not used when TIMEOUT_CYCLES=0, so a cycle waits forever.
// TESTING
//  1. Read: valid, addr=0x100, sel=F; slave acks 3 cycles later with dat=0xDEADBEEF
//     -> one core_ack_o pulse, core_data_o=0xDEADBEEF, err=0, cyc/stb high exactly 3 cycles.
//  2. Write: addr=0x200, data=0x12345678, sel=0011, we=1; zero-wait ack
//     -> wb_dat_o/wb_sel_o/wb_we_o match during stb, single ack pulse.
//  3. Error: wb_err_i and wb_ack_i both high in the same cycle
//     -> core_ack_o=1 and core_err_o=1 for one cycle, core_data_o=0.
//  4. Timeout: TIMEOUT_CYCLES=8, slave silent
//     -> stb high exactly 8 cycles, then ack+err pulse; slave ack 2 cycles later ignored.
//  5. Reset after 2 cycles in BUS -> cyc/stb/busy low after the edge, no core_ack_o; next request runs normally.
//  6. Back-to-back: core re-asserts valid immediately after ack
//     -> second request starts one cycle later, no lost or duplicate acks over 100 random requests.

Source files
------------

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//   Bridges a core valid/ack memory port onto a Wishbone B4 classic master.
//   All bus outputs come straight from flops. Bus errors are reported to the
//   core as an ack+err pulse. A watchdog does the same when a cycle hangs.
//   Use one instance per core port: the ibus with WR_EN=0, the dbus with WR_EN=1.
//
// Ports
//   wb_clk_i, wb_rst_i       clock and synchronous active-high reset
//   core_valid_i .. _we_i    core request, held by the core until core_ack_o
//   core_data_o              read data, valid while core_ack_o is high
//   core_ack_o / core_err_o  one-cycle completion pulse / error qualifier
//   wb_*_o / wb_*_i          Wishbone classic master interface
//   busy_o                   high while a bus cycle is outstanding
// -----------------------------------------------------------------------------
module wb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WR_EN          = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                core_valid_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_data_i,
    input  logic [DATA_W/8-1:0] core_sel_i,
    input  logic                core_we_i,
    output logic [DATA_W-1:0]   core_data_o,
    output logic                core_ack_o,
    output logic                core_err_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic                busy_o
);

    localparam int SEL_W = DATA_W / 8;
    // A width of at least 1 keeps the timer legal when the watchdog is disabled.
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic WE_EN  = (WR_EN != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [TMR_W-1:0]    timer_q,  timer_d;
    logic [ADDR_W-1:0]   adr_q,    adr_d;
    logic [DATA_W-1:0]   wdat_q,   wdat_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic                we_q,     we_d;
    logic                cyc_q,    cyc_d;
    logic                ack_q,    ack_d;
    logic                err_q,    err_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                timeout_s;

    // The watchdog fires on the last allowed bus cycle without a slave response.
    assign timeout_s = TMO_EN & (timer_q == TMR_LAST);

    // Next-state and next-output computation for the two-state bridge FSM.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                // ack_q gating drops the stale valid that the core still holds
                // during its ack cycle.
                if (core_valid_i && !ack_q) begin
                    adr_d   = core_addr_i;
                    wdat_d  = core_data_i;
                    sel_d   = core_sel_i;
                    we_d    = WE_EN & core_we_i;
                    cyc_d   = 1'b1;
                    timer_d = {TMR_W{1'b0}};
                    state_d = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TMR_W'(1);
                end else begin
                    timer_d = timer_q;
                end
                // Priority order: error, then ack, then watchdog.
                if (wb_err_i) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = {DATA_W{1'b0}};
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (wb_ack_i) begin
                    ack_d   = 1'b1;
                    rdata_d = wb_dat_i;
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = {DATA_W{1'b0}};
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUS;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including an open cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= {TMR_W{1'b0}};
            adr_q   <= {ADDR_W{1'b0}};
            wdat_q  <= {DATA_W{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign core_data_o = rdata_q;
    assign core_ack_o  = ack_q;
    assign core_err_o  = err_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = wdat_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_stb_o    = cyc_q;
    assign wb_cyc_o    = cyc_q;
    assign busy_o      = (state_q == ST_BUS);

endmodule

// File: tb/tb_wb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_master_bridge
//   Scoreboard bench for wb_master_bridge (TIMEOUT_CYCLES=8, writes enabled).
//   The stimulus pushes the expected {err,data} for each request it issues.
//   A negedge monitor pops one entry per core_ack_o and compares it.
//   A behavioural slave answers after a programmable number of strobe cycles.
// -----------------------------------------------------------------------------
module tb_wb_master_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_sel;
    logic        core_we;
    logic [31:0] core_rdata;
    logic        core_ack;
    logic        core_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;

    // Slave model controls and observations.
    int          slv_lat     = 0;
    bit          slv_errmode = 1'b0;
    logic [31:0] slv_rdata   = 32'h0;
    logic        slv_ack     = 1'b0;
    logic        slv_err     = 1'b0;
    logic        inj_ack     = 1'b0;
    int          stb_cnt     = 0;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;
    int          stable_bad  = 0;

    // Scoreboard and counters.
    logic [32:0] exp_q[$];
    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_acks   = 0;
    int          n_issued = 0;
    int          run_len  = 0;
    int          last_run = 0;

    assign wb_ack_i = slv_ack | inj_ack;
    assign wb_err_i = slv_err;
    assign wb_dat_i = slv_ack ? slv_rdata : 32'h0;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .WR_EN(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk),          .wb_rst_i(rst),
        .core_valid_i(core_valid), .core_addr_i(core_addr),
        .core_data_i(core_wdata),  .core_sel_i(core_sel),
        .core_we_i(core_we),       .core_data_o(core_rdata),
        .core_ack_o(core_ack),     .core_err_o(core_err),
        .wb_adr_o(wb_adr),         .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),       .wb_we_o(wb_we),
        .wb_sel_o(wb_sel),         .wb_stb_o(wb_stb),
        .wb_cyc_o(wb_cyc),         .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),       .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: acks on the slv_lat-th strobe cycle; slv_lat=0 never answers.
    always @(posedge clk) begin
        #1;
        if (wb_cyc && wb_stb) begin
            stb_cnt = stb_cnt + 1;
            if (stb_cnt == 1) begin
                cap_adr = wb_adr; cap_dat = wb_dat_o; cap_sel = wb_sel; cap_we = wb_we;
            end else if ({wb_adr, wb_dat_o, wb_sel, wb_we} !== {cap_adr, cap_dat, cap_sel, cap_we}) begin
                stable_bad = stable_bad + 1;
            end
            slv_ack = (slv_lat != 0) && (stb_cnt == slv_lat);
            slv_err = slv_ack && slv_errmode;
        end else begin
            stb_cnt = 0;
            slv_ack = 1'b0;
            slv_err = 1'b0;
        end
    end

    // Monitor: strobe run length and scoreboard comparison on each ack pulse.
    always @(negedge clk) begin
        if (wb_stb) begin
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (core_ack) begin
            n_acks = n_acks + 1;
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_ack: got ack err=%0b data=%0h expected none at %0t",
                         core_err, core_rdata, $time);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("ack_err", core_err, e[32]);
                check("ack_data", core_rdata, e[31:0]);
            end
        end else if (core_err) begin
            n_vec++; n_err++;
            $display("FAIL err_without_ack: got err=1 ack=0 expected err=0 at %0t", $time);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request (called at posedge+1); valid stays high after the ack.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic we, input int lat, input bit errm,
                         input logic [31:0] rdat, output int start_k);
        bit got;
        slv_lat = lat; slv_errmode = errm; slv_rdata = rdat;
        core_addr = a; core_wdata = d; core_sel = s; core_we = we; core_valid = 1'b1;
        exp_q.push_back((errm || lat == 0) ? {1'b1, 32'h0} : {1'b0, rdat});
        n_issued++;
        start_k = 0;
        got = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (wb_stb && start_k == 0) start_k = k;
            if (core_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL ack_wait: got no ack expected ack within 60 cycles (addr %0h)", a);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation ran out of time");
        $fatal(1);
    end

    initial begin
        int sk;
        int acks_before;
        rst = 1'b1; core_valid = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        core_sel = 4'h0; core_we = 1'b0;
        wait_cyc(3);
        check("rst_ack", core_ack, 1'b0);
        check("rst_err", core_err, 1'b0);
        check("rst_data", core_rdata, 32'h0);
        check("rst_cyc_stb_busy", {wb_cyc, wb_stb, busy}, 3'b000);
        check("rst_bus_fields", {wb_adr, wb_dat_o, wb_sel, wb_we}, 69'h0);
        rst = 1'b0;
        wait_cyc(2);

        // 1: read, slave answers on the third strobe cycle.
        issue(32'h100, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'hDEADBEEF, sk);
        check("t1_data_at_ack", core_rdata, 32'hDEADBEEF);
        core_valid = 1'b0;
        check("t1_stb_latency", sk, 1);
        check("t1_bus_fields", {cap_adr, cap_sel, cap_we}, {32'h100, 4'hF, 1'b0});
        @(negedge clk); #1;
        check("t1_stb_len", last_run, 3);
        wait_cyc(3);
        check("t1_data_hold", core_rdata, 32'hDEADBEEF);
        check("t1_idle_busy", {busy, wb_cyc}, 2'b00);

        // 2: write with zero-wait ack.
        issue(32'h200, 32'h12345678, 4'b0011, 1'b1, 1, 1'b0, 32'h0, sk);
        core_valid = 1'b0;
        check("t2_wr_fields", {cap_adr, cap_dat, cap_sel, cap_we}, {32'h200, 32'h12345678, 4'b0011, 1'b1});
        @(negedge clk); #1;
        check("t2_stb_len", last_run, 1);
        wait_cyc(2);

        // 3: err and ack together; err wins and data is cleared.
        issue(32'h300, 32'h0, 4'hF, 1'b0, 2, 1'b1, 32'hCAFEF00D, sk);
        check("t3_ack_err", {core_ack, core_err}, 2'b11);
        check("t3_data", core_rdata, 32'h0);
        core_valid = 1'b0;
        wait_cyc(2);

        // 4: silent slave, watchdog after TMO strobe cycles; late ack ignored.
        issue(32'h400, 32'h0, 4'hF, 1'b0, 0, 1'b0, 32'h0, sk);
        core_valid = 1'b0;
        @(negedge clk); #1;
        check("t4_stb_len", last_run, TMO);
        @(posedge clk); #1;
        acks_before = n_acks;
        inj_ack = 1'b1;
        wait_cyc(1);
        inj_ack = 1'b0;
        wait_cyc(3);
        check("t4_late_ack_ignored", n_acks, acks_before);
        check("t4_idle", {busy, wb_cyc, wb_stb}, 3'b000);

        // 5: reset two cycles into a bus cycle.
        slv_lat = 0; slv_errmode = 1'b0;
        core_addr = 32'h500; core_sel = 4'hF; core_we = 1'b0; core_valid = 1'b1;
        wait_cyc(3);
        check("t5_in_bus", {busy, wb_cyc}, 2'b11);
        rst = 1'b1; core_valid = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        check("t5_rst_drop", {wb_cyc, wb_stb, busy, core_ack}, 4'b0000);
        acks_before = n_acks;
        wait_cyc(3);
        check("t5_no_ack", n_acks, acks_before);
        issue(32'h504, 32'h0, 4'hF, 1'b0, 2, 1'b0, 32'h5A5A1234, sk);
        core_valid = 1'b0;
        check("t5_after_rst_data", core_rdata, 32'h5A5A1234);
        wait_cyc(2);

        // 6: 100 back-to-back random requests; valid never drops between them.
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra, rd, rr;
            ra = $urandom; rd = $urandom; rr = $urandom;
            issue(ra, rd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 6), ($urandom_range(0, 9) == 0), rr, sk);
            if (i > 0) check("t6_b2b_start", sk, 2);
        end
        core_valid = 1'b0;
        wait_cyc(5);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ack_count", n_acks, n_issued);
        check("final_bus_stable", stable_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
